dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Shares one single-port synchronous data RAM (word-addressed, byte write mask, 1-cycle read latency) between two requesters:
  - the core's data-memory port (CPU);
  - a DMA / program-loader port (DMA), e.g. a UART boot loader.
- Sits between the core's mem_addr/mem_wmask/mem_wdata/mem_data interface and the RAM.
- Issues at most one RAM access per cycle and returns read data to the owner of that access.
- Drives a stall to the core when the CPU loses arbitration; bounds starvation with a burst counter.

Parameters:
- ADDR_W, 21, word-address width (RAM depth 2^ADDR_W words of 32 bits).
- MAX_BURST, 4, max consecutive grants to one requester while the other is waiting; range 1..15.

Ports:
- clk  in  1  clock.
- resetn  in  1  synchronous, active-low reset.
- cpu_req  in  1  CPU access request this cycle.
- cpu_addr  in  ADDR_W  CPU word address.
- cpu_wmask  in  4  CPU byte write mask; 0 = read.
- cpu_wdata  in  32  CPU write data.
- cpu_stall  out  1  CPU request present but not granted this cycle.
- cpu_rdata  out  32  read data returned to the CPU.
- cpu_rvalid  out  1  cpu_rdata valid (1 cycle after a granted CPU read).
- dma_req  in  1  DMA access request.
- dma_addr  in  ADDR_W  DMA word address.
- dma_wmask  in  4  DMA byte write mask; 0 = read.
- dma_wdata  in  32  DMA write data.
- dma_gnt  out  1  DMA request accepted this cycle.
- dma_rdata  out  32  read data returned to the DMA.
- dma_rvalid  out  1  dma_rdata valid.
- ram_addr  out  ADDR_W  RAM address.
- ram_wmask  out  4  RAM byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid the cycle after the address is presented.

Behaviour:
- Grants are combinational from the request lines and registered state. The granted request is driven onto the ram_* outputs in the same cycle.
- cpu_gnt is internal. cpu_stall = cpu_req & !cpu_gnt. dma_gnt is output.
- When no request is granted: ram_wmask = 0 and ram_addr/ram_wdata hold the CPU values. No spurious write may occur.
- Registered state:
  - owner ∈ {OWN_CPU, OWN_DMA}: the last granted requester.
  - run_cnt, 4 bits.
  - rd_pend_cpu, rd_pend_dma: read issued last cycle.
- Arbitration:
  - Only one requester asserting: that requester is granted.
  - Both asserting: the owner is granted while run_cnt < MAX_BURST; otherwise the other requester is granted.
  - Neither asserting: no grant; owner is unchanged.
- Transitions on a grant:
  - Grantee == owner: run_cnt increments (saturating at 15) if the other requester is also asserting; otherwise run_cnt is cleared.
  - Grantee != owner: owner <= grantee; run_cnt <= 1 if the other requester is still asserting, else 0.
- Read return:
  - A granted access with wmask == 0 sets the matching rd_pend_* for the next cycle.
  - x_rvalid = rd_pend_x.
  - x_rdata = ram_rdata when rd_pend_x; otherwise 0.
  - Writes produce no rvalid.
- Latency:
  - Read: grant cycle N, rvalid/rdata cycle N+1.
  - Write: committed at the end of the grant cycle.
  - A write in cycle N followed by a read of the same address in N+1 returns the new data.
- Simultaneous writes to the same address: only the grantee writes; the loser retries in a later cycle (CPU held by stall; DMA holds its request until dma_gnt).
- Requester protocol:
  - Request fields must stay stable while the request is pending without a grant.
  - Dropping a request before grant is legal; no access occurs.
- Reset (resetn low at a clock edge):
  - owner = OWN_CPU, run_cnt = 0, rd_pend_* = 0.
  - Outputs rvalid = 0, rdata = 0.
  - Reset while a read is in flight: its rvalid is discarded.
- While resetn is low: no grants, ram_wmask = 0, cpu_stall = 0, dma_gnt = 0.

Optional Feature:
- Macro: DMEM_ARB_LOCK_EN.
- Defined: adds input dma_lock (1 bit).
  - While dma_lock = 1 and owner == OWN_DMA and dma_req = 1, the DMA is granted regardless of run_cnt; the CPU stalls.
  - dma_lock is ignored when the owner is the CPU; the DMA must first win normally.
- Not defined: no dma_lock port; fairness is governed solely by MAX_BURST.

Decomposition:
- Shared package dmem_arb_pkg:
  - owner encoding constants OWN_CPU = 1'b0, OWN_DMA = 1'b1;
  - RUN_CNT_W = 4;
  - WMASK_READ = 4'b0000.
- One natural sub-module, dmem_arb_fair: owner/run_cnt state plus the grant decision. Inputs: the two requests (and dma_lock when enabled). Outputs: cpu_gnt/dma_gnt.
- The top level keeps the datapath muxes and the read-return pipeline.

Test Plan:
- CPU alone:
  - Write 0xDEADBEEF, wmask 1111, addr 5, then read addr 5 -> cpu_stall = 0 throughout.
  - cpu_rvalid = 1 with 0xDEADBEEF one cycle after the read; dma_rvalid stays 0.
- DMA alone:
  - Byte write 0xAB, wmask 0100, to a word holding 0x11223344 -> read returns 0x11AB3344.
  - dma_gnt = 1 on each request cycle.
- Both requesting continuously, MAX_BURST = 4, from reset:
  - Grants are CPU x4, DMA x4, CPU x4, ...
  - cpu_stall is high exactly on the DMA cycles.
- Simultaneous writes to addr 7: CPU 0x1, DMA 0x2 (owner = CPU, run_cnt 0):
  - CPU write lands first, DMA next cycle.
  - A final read of addr 7 returns 0x2.
- resetn pulsed low the cycle after a granted CPU read:
  - cpu_rvalid = 0, owner = CPU, run_cnt = 0 after reset.
  - No RAM write during reset.
- DMEM_ARB_LOCK_EN with dma_lock = 1 after the DMA wins:
  - DMA is granted for 10 consecutive cycles while cpu_req = 1.
  - The CPU is granted in the first cycle after dma_lock drops, since run_cnt ≥ MAX_BURST.

Source files
------------

// File: rtl/dmem_arb_pkg.sv
// Shared types and constants for the data-memory arbiter between the core and
// the DMA/boot-loader port.
package dmem_arb_pkg;

   typedef enum logic {
      OWN_CPU = 1'b0,
      OWN_DMA = 1'b1
   } owner_e;

   localparam int         RUN_CNT_W  = 4;
   localparam logic [3:0] WMASK_READ = 4'b0000;

   function automatic logic [RUN_CNT_W-1:0] sat_inc(input logic [RUN_CNT_W-1:0] v);
      return (&v) ? v : v + RUN_CNT_W'(1);
   endfunction

endpackage

// File: rtl/dmem_arb_fair.sv
// Owner/run-length state and grant decision for the two RAM requesters.
// Optional DMA lock input exists only when DMEM_ARB_LOCK_EN is defined.
//
// owner_q | meaning
// --------+-----------------------------------------------
// OWN_CPU | CPU won the most recent grant (reset value)
// OWN_DMA | DMA won the most recent grant
module dmem_arb_fair
   import dmem_arb_pkg::*;
#(
   parameter int MAX_BURST = 4
) (
   input  logic clk,
   input  logic resetn,
   input  logic cpu_req,
   input  logic dma_req,
`ifdef DMEM_ARB_LOCK_EN
   input  logic dma_lock,
`endif
   output logic cpu_gnt,
   output logic dma_gnt
);

   owner_e                 owner_q, owner_d;
   logic [RUN_CNT_W-1:0]   run_cnt_q, run_cnt_d;
   logic                   lock_hold;
   logic                   keep_owner;
   logic                   other_req;
   owner_e                 grantee;

`ifdef DMEM_ARB_LOCK_EN
   assign lock_hold = dma_lock & dma_req & (owner_q == OWN_DMA);
`else
   assign lock_hold = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!resetn) begin
         owner_q   <= OWN_CPU;
         run_cnt_q <= '0;
      end else begin
         owner_q   <= owner_d;
         run_cnt_q <= run_cnt_d;
      end
   end

   // run_cnt counts contested grants to the current owner
   always_comb begin
      owner_d   = owner_q;
      run_cnt_d = run_cnt_q;
      other_req = (cpu_gnt & dma_req) | (dma_gnt & cpu_req);
      grantee   = dma_gnt ? OWN_DMA : OWN_CPU;
      if (cpu_gnt || dma_gnt) begin
         if (grantee == owner_q) begin
            run_cnt_d = other_req ? sat_inc(run_cnt_q) : '0;
         end else begin
            owner_d   = grantee;
            run_cnt_d = other_req ? RUN_CNT_W'(1) : '0;
         end
      end
   end

   always_comb begin
      cpu_gnt    = 1'b0;
      dma_gnt    = 1'b0;
      keep_owner = lock_hold || (int'(run_cnt_q) < MAX_BURST);
      if (resetn) begin
         if (cpu_req && dma_req) begin
            if ((owner_q == OWN_CPU) == keep_owner) cpu_gnt = 1'b1;
            else                                    dma_gnt = 1'b1;
         end else begin
            cpu_gnt = cpu_req;
            dma_gnt = dma_req;
         end
      end
   end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares one single-port data RAM between the core data port and a DMA port.
// Define DMEM_ARB_LOCK_EN to add the dma_lock input.
module dmem_arbiter
   import dmem_arb_pkg::*;
#(
   parameter int ADDR_W    = 21,
   parameter int MAX_BURST = 4
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              cpu_req,
   input  logic [ADDR_W-1:0] cpu_addr,
   input  logic [3:0]        cpu_wmask,
   input  logic [31:0]       cpu_wdata,
   output logic              cpu_stall,
   output logic [31:0]       cpu_rdata,
   output logic              cpu_rvalid,
   input  logic              dma_req,
   input  logic [ADDR_W-1:0] dma_addr,
   input  logic [3:0]        dma_wmask,
   input  logic [31:0]       dma_wdata,
`ifdef DMEM_ARB_LOCK_EN
   input  logic              dma_lock,
`endif
   output logic              dma_gnt,
   output logic [31:0]       dma_rdata,
   output logic              dma_rvalid,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [3:0]        ram_wmask,
   output logic [31:0]       ram_wdata,
   input  logic [31:0]       ram_rdata
);

   logic cpu_gnt;
   logic rd_pend_cpu_d, rd_pend_cpu_q;
   logic rd_pend_dma_d, rd_pend_dma_q;

   dmem_arb_fair #(.MAX_BURST(MAX_BURST)) u_fair (
      .clk     (clk),
      .resetn  (resetn),
      .cpu_req (cpu_req),
      .dma_req (dma_req),
`ifdef DMEM_ARB_LOCK_EN
      .dma_lock(dma_lock),
`endif
      .cpu_gnt (cpu_gnt),
      .dma_gnt (dma_gnt)
   );

   // Idle cycles leave the CPU address/data on the bus with writes disabled
   always_comb begin
      ram_addr  = dma_gnt ? dma_addr  : cpu_addr;
      ram_wdata = dma_gnt ? dma_wdata : cpu_wdata;
      ram_wmask = cpu_gnt ? cpu_wmask : (dma_gnt ? dma_wmask : WMASK_READ);
   end

   assign cpu_stall = resetn & cpu_req & ~cpu_gnt;

   always_comb begin
      rd_pend_cpu_d = cpu_gnt && (cpu_wmask == WMASK_READ);
      rd_pend_dma_d = dma_gnt && (dma_wmask == WMASK_READ);
   end

   always_ff @(posedge clk) begin
      if (!resetn) begin
         rd_pend_cpu_q <= 1'b0;
         rd_pend_dma_q <= 1'b0;
      end else begin
         rd_pend_cpu_q <= rd_pend_cpu_d;
         rd_pend_dma_q <= rd_pend_dma_d;
      end
   end

   // A read in flight when reset asserts never reports valid
   assign cpu_rvalid = resetn & rd_pend_cpu_q;
   assign dma_rvalid = resetn & rd_pend_dma_q;
   assign cpu_rdata  = cpu_rvalid ? ram_rdata : 32'h0;
   assign dma_rdata  = dma_rvalid ? ram_rdata : 32'h0;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Self-checking bench for dmem_arbiter: directed scenarios plus randomized
// traffic against a grant-history reference model.
module tb_dmem_arbiter;

   localparam int ADDR_W    = 21;
   localparam int MAX_BURST = 4;

   logic              clk = 1'b0;
   logic              resetn;
   logic              cpu_req;
   logic [ADDR_W-1:0] cpu_addr;
   logic [3:0]        cpu_wmask;
   logic [31:0]       cpu_wdata;
   logic              cpu_stall;
   logic [31:0]       cpu_rdata;
   logic              cpu_rvalid;
   logic              dma_req;
   logic [ADDR_W-1:0] dma_addr;
   logic [3:0]        dma_wmask;
   logic [31:0]       dma_wdata;
   logic              dma_lock;
   logic              dma_gnt;
   logic [31:0]       dma_rdata;
   logic              dma_rvalid;
   logic [ADDR_W-1:0] ram_addr;
   logic [3:0]        ram_wmask;
   logic [31:0]       ram_wdata;
   logic [31:0]       ram_rdata;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_W(ADDR_W), .MAX_BURST(MAX_BURST)) dut (
      .clk       (clk),
      .resetn    (resetn),
      .cpu_req   (cpu_req),
      .cpu_addr  (cpu_addr),
      .cpu_wmask (cpu_wmask),
      .cpu_wdata (cpu_wdata),
      .cpu_stall (cpu_stall),
      .cpu_rdata (cpu_rdata),
      .cpu_rvalid(cpu_rvalid),
      .dma_req   (dma_req),
      .dma_addr  (dma_addr),
      .dma_wmask (dma_wmask),
      .dma_wdata (dma_wdata),
`ifdef DMEM_ARB_LOCK_EN
      .dma_lock  (dma_lock),
`endif
      .dma_gnt   (dma_gnt),
      .dma_rdata (dma_rdata),
      .dma_rvalid(dma_rvalid),
      .ram_addr  (ram_addr),
      .ram_wmask (ram_wmask),
      .ram_wdata (ram_wdata),
      .ram_rdata (ram_rdata)
   );

   // Single-port RAM with byte enables and one cycle of read latency
   logic [31:0] ram_mem [0:63];
   always @(posedge clk) begin
      for (int b = 0; b < 4; b++)
         if (ram_wmask[b]) ram_mem[ram_addr[5:0]][8*b +: 8] <= ram_wdata[8*b +: 8];
      ram_rdata <= ram_mem[ram_addr[5:0]];
   end

   // Reference model: memory image, pending read results and grant history
   typedef struct packed {
      logic who;
      logic contested;
   } gev_t;

   gev_t        hist[$];
   logic [31:0] ref_mem [0:31];
   bit          exp_cpu_rv, exp_dma_rv;
   logic [31:0] exp_cpu_rd, exp_dma_rd;

   function automatic void model_reset();
      hist.delete();
      exp_cpu_rv = 1'b0;
      exp_dma_rv = 1'b0;
      exp_cpu_rd = 32'h0;
      exp_dma_rd = 32'h0;
   endfunction

   // Owner = last grantee; its streak = trailing grants it won while the other waited
   function automatic void model_decide(output bit gc, output bit gd);
      bit own;
      bit dma_turn;
      int run;
      gc  = 1'b0;
      gd  = 1'b0;
      own = (hist.size() != 0) ? hist[hist.size()-1].who : 1'b0;
      run = 0;
      for (int i = hist.size() - 1; i >= 0; i--) begin
         if (hist[i].who == own && hist[i].contested) run++;
         else break;
      end
      if (cpu_req && !dma_req) gc = 1'b1;
      else if (dma_req && !cpu_req) gd = 1'b1;
      else if (cpu_req && dma_req) begin
         dma_turn = (run < MAX_BURST) ? own : !own;
`ifdef DMEM_ARB_LOCK_EN
         if (dma_lock && own) dma_turn = 1'b1;
`endif
         gd = dma_turn;
         gc = !dma_turn;
      end
   endfunction

   function automatic void model_commit(input bit gc, input bit gd);
      gev_t        e;
      logic [4:0]  ad;
      logic [3:0]  wm;
      logic [31:0] wd;
      exp_cpu_rv = 1'b0;
      exp_dma_rv = 1'b0;
      exp_cpu_rd = 32'h0;
      exp_dma_rd = 32'h0;
      if (gc || gd) begin
         e.who       = gd;
         e.contested = gd ? cpu_req : dma_req;
         hist.push_back(e);
         if (hist.size() > 32) void'(hist.pop_front());
         ad = gd ? dma_addr[4:0] : cpu_addr[4:0];
         wm = gd ? dma_wmask : cpu_wmask;
         wd = gd ? dma_wdata : cpu_wdata;
         if (wm == 4'h0) begin
            if (gd) begin exp_dma_rv = 1'b1; exp_dma_rd = ref_mem[ad]; end
            else    begin exp_cpu_rv = 1'b1; exp_cpu_rd = ref_mem[ad]; end
         end else begin
            for (int b = 0; b < 4; b++)
               if (wm[b]) ref_mem[ad][8*b +: 8] = wd[8*b +: 8];
         end
      end
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_cpu(input logic r, input int a, input logic [3:0] m, input logic [31:0] d);
      cpu_req   = r;
      cpu_addr  = ADDR_W'(a);
      cpu_wmask = m;
      cpu_wdata = d;
   endtask

   task automatic set_dma(input logic r, input int a, input logic [3:0] m, input logic [31:0] d);
      dma_req   = r;
      dma_addr  = ADDR_W'(a);
      dma_wmask = m;
      dma_wdata = d;
   endtask

   task automatic idle();
      set_cpu(1'b0, 0, 4'h0, 32'h0);
      set_dma(1'b0, 0, 4'h0, 32'h0);
   endtask

   task automatic do_reset();
      resetn = 1'b0;
      idle();
      tick();
      resetn = 1'b1;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      set_cpu(1'b1, 3, 4'hF, 32'h12345678);
      set_dma(1'b1, 3, 4'hF, 32'h87654321);
      tick();
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
      checks++; if (dma_gnt !== 1'b0) begin errors++; $display("FAIL reset_dma_gnt: got %b want 0", dma_gnt); end
      checks++; if (ram_wmask !== 4'h0) begin errors++; $display("FAIL reset_wmask: got %h want 0", ram_wmask); end
      checks++; if (cpu_rvalid !== 1'b0 || dma_rvalid !== 1'b0) begin errors++; $display("FAIL reset_rvalid: got %b/%b want 0/0", cpu_rvalid, dma_rvalid); end
      checks++; if (cpu_rdata !== 32'h0 || dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h/%h want 0/0", cpu_rdata, dma_rdata); end
      tick();
      resetn = 1'b1;
      idle();
   endtask

   task automatic test_cpu_alone();
      set_cpu(1'b1, 5, 4'hF, 32'hDEADBEEF);
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b0) begin errors++; $display("FAIL cpu_wr_stall: got %b want 0", cpu_stall); end
      checks++; if (ram_wmask !== 4'hF || ram_addr !== ADDR_W'(5)) begin errors++; $display("FAIL cpu_wr_bus: got mask %h addr %0d want F 5", ram_wmask, ram_addr); end
      tick();
      set_cpu(1'b1, 5, 4'h0, 32'h0);
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b0 || cpu_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_issue: got stall %b rvalid %b want 0 0", cpu_stall, cpu_rvalid); end
      tick();
      idle();
      @(negedge clk);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL cpu_rd_data: got %b %h want 1 deadbeef", cpu_rvalid, cpu_rdata); end
      checks++; if (dma_rvalid !== 1'b0) begin errors++; $display("FAIL cpu_rd_dma_rvalid: got %b want 0", dma_rvalid); end
      tick();
   endtask

   task automatic test_dma_alone();
      set_dma(1'b1, 9, 4'hF, 32'h11223344);
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL dma_wr_gnt: got %b want 1", dma_gnt); end
      tick();
      set_dma(1'b1, 9, 4'b0100, 32'h00AB0000);
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1 || ram_wmask !== 4'b0100) begin errors++; $display("FAIL dma_byte_gnt: got %b mask %h want 1 4", dma_gnt, ram_wmask); end
      tick();
      set_dma(1'b1, 9, 4'h0, 32'h0);
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1) begin errors++; $display("FAIL dma_rd_gnt: got %b want 1", dma_gnt); end
      tick();
      idle();
      @(negedge clk);
      checks++; if (dma_rvalid !== 1'b1 || dma_rdata !== 32'h11AB3344) begin errors++; $display("FAIL dma_rd_data: got %b %h want 1 11ab3344", dma_rvalid, dma_rdata); end
      checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL dma_rd_cpu_rvalid: got %b want 0", cpu_rvalid); end
      tick();
   endtask

   task automatic test_burst();
      logic exp_c;
      do_reset();
      set_cpu(1'b1, 1, 4'h0, 32'h0);
      set_dma(1'b1, 2, 4'h0, 32'h0);
      for (int i = 0; i < 16; i++) begin
         exp_c = ((i / MAX_BURST) % 2) == 0;
         @(negedge clk);
         checks++; if (dma_gnt !== !exp_c || cpu_stall !== !exp_c) begin errors++; $display("FAIL burst_%0d: got gnt %b stall %b want %b %b", i, dma_gnt, cpu_stall, !exp_c, !exp_c); end
         tick();
      end
      idle();
   endtask

   task automatic test_same_addr();
      do_reset();
      set_cpu(1'b1, 7, 4'hF, 32'h1);
      set_dma(1'b1, 7, 4'hF, 32'h2);
      @(negedge clk);
      checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0 || ram_wdata !== 32'h1) begin errors++; $display("FAIL same_addr_cpu: got stall %b gnt %b data %h want 0 0 1", cpu_stall, dma_gnt, ram_wdata); end
      tick();
      set_cpu(1'b0, 0, 4'h0, 32'h0);
      @(negedge clk);
      checks++; if (dma_gnt !== 1'b1 || ram_wdata !== 32'h2 || ram_wmask !== 4'hF) begin errors++; $display("FAIL same_addr_dma: got gnt %b data %h mask %h want 1 2 F", dma_gnt, ram_wdata, ram_wmask); end
      tick();
      set_dma(1'b0, 0, 4'h0, 32'h0);
      set_cpu(1'b1, 7, 4'h0, 32'h0);
      @(negedge clk);
      tick();
      idle();
      @(negedge clk);
      checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'h2) begin errors++; $display("FAIL same_addr_final: got %b %h want 1 2", cpu_rvalid, cpu_rdata); end
      tick();
   endtask

   task automatic test_reset_inflight();
      logic exp_c;
      do_reset();
      set_cpu(1'b1, 5, 4'h0, 32'h0);
      set_dma(1'b1, 9, 4'h0, 32'h0);
      for (int i = 0; i < 2; i++) begin
         @(negedge clk);
         checks++; if (cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL inflight_pre_%0d: got stall %b gnt %b want 0 0", i, cpu_stall, dma_gnt); end
         tick();
      end
      resetn = 1'b0;
      set_cpu(1'b1, 5, 4'hF, 32'h0BAD0BAD);
      set_dma(1'b1, 9, 4'hF, 32'h0BAD0BAD);
      @(negedge clk);
      checks++; if (cpu_rvalid !== 1'b0 || cpu_rdata !== 32'h0) begin errors++; $display("FAIL inflight_rvalid: got %b %h want 0 0", cpu_rvalid, cpu_rdata); end
      checks++; if (ram_wmask !== 4'h0 || cpu_stall !== 1'b0 || dma_gnt !== 1'b0) begin errors++; $display("FAIL inflight_quiet: got mask %h stall %b gnt %b want 0 0 0", ram_wmask, cpu_stall, dma_gnt); end
      tick();
      resetn = 1'b1;
      set_cpu(1'b1, 5, 4'h0, 32'h0);
      set_dma(1'b1, 9, 4'h0, 32'h0);
      for (int i = 0; i < 5; i++) begin
         exp_c = (i < MAX_BURST);
         @(negedge clk);
         checks++; if (cpu_stall !== !exp_c || dma_gnt !== !exp_c) begin errors++; $display("FAIL inflight_post_%0d: got stall %b gnt %b want %b %b", i, cpu_stall, dma_gnt, !exp_c, !exp_c); end
         if (i == 0) begin
            checks++; if (cpu_rvalid !== 1'b0) begin errors++; $display("FAIL inflight_post_rvalid: got %b want 0", cpu_rvalid); end
         end
         if (i == 1) begin
            checks++; if (cpu_rvalid !== 1'b1 || cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL inflight_no_write: got %b %h want 1 deadbeef", cpu_rvalid, cpu_rdata); end
         end
         tick();
      end
      idle();
   endtask

`ifdef DMEM_ARB_LOCK_EN
   task automatic test_lock();
      logic exp_c;
      do_reset();
      dma_lock = 1'b1;
      set_cpu(1'b1, 1, 4'h0, 32'h0);
      set_dma(1'b1, 2, 4'h0, 32'h0);
      for (int i = 0; i < MAX_BURST + 11; i++) begin
         if (i == MAX_BURST + 10) dma_lock = 1'b0;
         exp_c = (i < MAX_BURST) || (i == MAX_BURST + 10);
         @(negedge clk);
         checks++; if (cpu_stall !== !exp_c || dma_gnt !== !exp_c) begin errors++; $display("FAIL lock_%0d: got stall %b gnt %b want %b %b", i, cpu_stall, dma_gnt, !exp_c, !exp_c); end
         tick();
      end
      dma_lock = 1'b0;
      idle();
   endtask
`endif

   task automatic test_random();
      bit          eg_c, eg_d, c_wait, d_wait;
      logic [3:0]  exp_wm;
      logic [ADDR_W-1:0] exp_addr;
      logic [31:0] exp_wd;
      do_reset();
      model_reset();
      for (int a = 0; a < 32; a++) begin
         set_cpu(1'b0, 0, 4'h0, 32'h0);
         set_dma(1'b1, a, 4'hF, $urandom);
         @(negedge clk);
         model_decide(eg_c, eg_d);
         checks++; if (dma_gnt !== eg_d) begin errors++; $display("FAIL preload_%0d: got gnt %b want %b", a, dma_gnt, eg_d); end
         model_commit(eg_c, eg_d);
         tick();
      end
      c_wait = 1'b0;
      d_wait = 1'b0;
      for (int n = 0; n < 400; n++) begin
         if (c_wait) begin
            if ($urandom_range(3) == 0) cpu_req = 1'b0;
         end else begin
            set_cpu($urandom_range(2) != 0, int'($urandom_range(31)),
                    ($urandom_range(1) != 0) ? 4'h0 : 4'($urandom_range(15)), $urandom);
         end
         if (d_wait) begin
            if ($urandom_range(3) == 0) dma_req = 1'b0;
         end else begin
            set_dma($urandom_range(2) != 0, int'($urandom_range(31)),
                    ($urandom_range(1) != 0) ? 4'h0 : 4'($urandom_range(15)), $urandom);
         end
         @(negedge clk);
         model_decide(eg_c, eg_d);
         exp_wm   = eg_c ? cpu_wmask : (eg_d ? dma_wmask : 4'h0);
         exp_addr = eg_d ? dma_addr  : cpu_addr;
         exp_wd   = eg_d ? dma_wdata : cpu_wdata;
         checks++; if (cpu_stall !== (cpu_req && !eg_c) || dma_gnt !== eg_d) begin errors++; $display("FAIL rand_gnt_%0d: got stall %b gnt %b want %b %b", n, cpu_stall, dma_gnt, cpu_req && !eg_c, eg_d); end
         checks++; if (ram_wmask !== exp_wm || ram_addr !== exp_addr || ram_wdata !== exp_wd) begin errors++; $display("FAIL rand_bus_%0d: got %h/%h/%h want %h/%h/%h", n, ram_wmask, ram_addr, ram_wdata, exp_wm, exp_addr, exp_wd); end
         checks++; if (cpu_rvalid !== exp_cpu_rv || cpu_rdata !== exp_cpu_rd) begin errors++; $display("FAIL rand_cpu_rd_%0d: got %b %h want %b %h", n, cpu_rvalid, cpu_rdata, exp_cpu_rv, exp_cpu_rd); end
         checks++; if (dma_rvalid !== exp_dma_rv || dma_rdata !== exp_dma_rd) begin errors++; $display("FAIL rand_dma_rd_%0d: got %b %h want %b %h", n, dma_rvalid, dma_rdata, exp_dma_rv, exp_dma_rd); end
         model_commit(eg_c, eg_d);
         c_wait = cpu_req && !eg_c;
         d_wait = dma_req && !eg_d;
         tick();
      end
      idle();
   endtask

   initial begin
      dma_lock = 1'b0;
      resetn   = 1'b0;
      idle();
      test_reset();
      test_cpu_alone();
      test_dma_alone();
      test_burst();
      test_same_addr();
      test_reset_inflight();
`ifdef DMEM_ARB_LOCK_EN
      test_lock();
`endif
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
